cpu_seq_ctl: RTL and testbench
==============================

CPU_SEQ_CTL -- requirements
Module: cpu_seq_ctl

Interface
REQ-001 Parameter: RSTCYCLES, default 4, number of clocks the CPU reset is held asserted (range 1..255).
REQ-002 Parameter: STEPTO, default 1023, step-timeout limit in clocks (range 1..65535).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 n_rst  input  1  reset, asynchronous, active-low.
REQ-005 cpuhalt, cpustart, cpustep, cpucycle, cpurst, cpuprint  input  1 each  single-cycle command pulses from the UART command decoder.
REQ-006 freeze  input  1  level; program upload in progress.
REQ-007 retired  input  1  CPU pulse, one instruction retired.
REQ-008 printdone  input  1  state-printer pulse, dump finished.
REQ-009 cpuen  output  1  CPU clock enable.
REQ-010 cpu_n_rst  output  1  CPU reset, active-low.
REQ-011 printreq  output  1  level; request to the state printer.
REQ-012 running  output  1  high only in RUN.
REQ-013 steperr  output  1  sticky step-timeout flag.
REQ-014 seqstate  output  3  current state encoding.
REQ-015 cyccnt  output  32  count of clocks with cpuen=1.

Function
REQ-016 States and encodings SHALL be HALT=0, RUN=1, STEP=2, CYCLE=3, PRINT=4, RESET=5; seqstate SHALL equal the current state register.
REQ-017 Command priority in the same cycle SHALL be cpurst > cpuhalt > cpustart > cpustep > cpucycle > cpuprint; lower-priority pulses that cycle SHALL be dropped.
REQ-018 cpurst in any state SHALL enter RESET next clock, load the reset counter with RSTCYCLES, and clear steperr.
REQ-019 RESET: cpu_n_rst=0, cpuen=0, counter decrements each clock; at count 1 go to HALT, so cpu_n_rst is low for exactly RSTCYCLES clocks.
REQ-020 HALT: cpuen=0; cpustart->RUN, cpustep->STEP, cpucycle->CYCLE, cpuprint->PRINT.
REQ-021 RUN: cpuen=1, running=1; cpuhalt->HALT; cpustep, cpucycle, cpuprint ignored.
REQ-022 STEP: cpuen=1 until the clock where retired=1 is sampled, then HALT; cpuen SHALL be 0 from the next clock.
REQ-023 STEP timeout: a 16-bit counter cleared on STEP entry increments per clock; reaching STEPTO without retired SHALL set steperr and go to HALT.
REQ-024 retired and timeout in the same clock SHALL count as retired (no steperr).
REQ-025 CYCLE: cpuen=1 for exactly one clock, then HALT.
REQ-026 PRINT: cpuen=0, printreq=1 held until printdone sampled high, then printreq=0 next clock and HALT.
REQ-027 cpuhalt in STEP, CYCLE or PRINT SHALL abort to HALT next clock, deasserting cpuen/printreq.
REQ-028 freeze=1 SHALL force cpuen=0 combinationally in every state and block all commands except cpurst; state and counters SHALL hold.
REQ-029 retired, printdone outside STEP/PRINT respectively SHALL be ignored.
REQ-030 Outputs cpuen, cpu_n_rst, printreq, running SHALL be registered-state decodes, no input-to-output path except freeze gating cpuen.

Reset
REQ-031 n_rst low SHALL asynchronously set state RESET with reset counter RSTCYCLES, steperr=0, step counter 0, cyccnt 0, printreq 0, cpuen 0, cpu_n_rst 0.
REQ-032 After n_rst release the block SHALL complete the RESET sequence of REQ-019 and settle in HALT.
REQ-033 n_rst mid-STEP, mid-PRINT or mid-RESET SHALL restart the RESET sequence from full count.

Configuration
REQ-034 Macro CPU_SEQ_CTL_CYCCNT_EN defined: cyccnt increments by 1 on every clock with cpuen=1, wraps 0xFFFFFFFF->0, cleared on cpurst and n_rst.
REQ-035 Macro undefined: no counter logic synthesized, cyccnt tied to 32'h0.

Verification
REQ-036 Release n_rst, RSTCYCLES=4 -> cpu_n_rst low 4 clocks, then seqstate=0, cpuen=0.
REQ-037 HALT, cpustep, retired on 3rd enabled clock -> cpuen high exactly 3 clocks, seqstate back to 0, steperr=0.
REQ-038 STEPTO=8, cpustep, no retired -> after 8 clocks steperr=1, HALT; later cpurst -> steperr=0.
REQ-039 cpustart and cpuhalt same cycle in HALT -> stays HALT; cpustart then freeze=1 -> cpuen=0 while state stays RUN, running=1.
REQ-040 cpuprint in HALT, printdone after 5 clocks -> printreq high 5 clocks then 0, HALT; cpuprint in RUN -> no printreq.
REQ-041 With CPU_SEQ_CTL_CYCCNT_EN: cpucycle x3 -> cyccnt=3; preset near 0xFFFFFFFF wraps to 0; without macro cyccnt=0 always.

Source files
------------

// File: rtl/cpu_seq_ctl.sv
// ---------------------------------------------------------------------------
// cpu_seq_ctl
//   Run-control sequencer for a debug-controlled CPU. It turns single-cycle
//   command pulses from the UART command decoder into a CPU clock enable,
//   a CPU reset and a request to the state printer. It supports free-running,
//   single-instruction step with timeout, single-clock cycle, a state dump,
//   and a timed CPU reset.
//
//   Optional feature: define CPU_SEQ_CTL_CYCCNT_EN to build the 32-bit
//   counter of enabled CPU clocks. Without the macro, cyccnt is tied to zero.
//
// Parameters
//   RSTCYCLES  clocks the CPU reset is held asserted (1..255)
//   STEPTO     step timeout in clocks (1..65535)
//
// Ports
//   clk        in   sole clock, rising edge
//   n_rst      in   asynchronous active-low reset
//   cpuhalt    in   command pulse: halt / abort
//   cpustart   in   command pulse: free run
//   cpustep    in   command pulse: execute one instruction
//   cpucycle   in   command pulse: enable the CPU for one clock
//   cpurst     in   command pulse: reset the CPU
//   cpuprint   in   command pulse: dump CPU state
//   freeze     in   level, program upload in progress
//   retired    in   CPU pulse, one instruction retired
//   printdone  in   state-printer pulse, dump finished
//   cpuen      out  CPU clock enable
//   cpu_n_rst  out  CPU reset, active-low
//   printreq   out  request to the state printer
//   running    out  high only in RUN
//   steperr    out  sticky step-timeout flag
//   seqstate   out  current state encoding
//   cyccnt     out  count of clocks with cpuen=1
// ---------------------------------------------------------------------------
module cpu_seq_ctl #(
  parameter int RSTCYCLES = 4,
  parameter int STEPTO    = 1023
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cpuhalt,
  input  logic        cpustart,
  input  logic        cpustep,
  input  logic        cpucycle,
  input  logic        cpurst,
  input  logic        cpuprint,
  input  logic        freeze,
  input  logic        retired,
  input  logic        printdone,
  output logic        cpuen,
  output logic        cpu_n_rst,
  output logic        printreq,
  output logic        running,
  output logic        steperr,
  output logic [2:0]  seqstate,
  output logic [31:0] cyccnt
);

  typedef enum logic [2:0] {
    HALT  = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    CYCLE = 3'd3,
    PRINT = 3'd4,
    RESET = 3'd5
  } state_e;

  localparam logic [7:0]  RstLoad  = 8'(RSTCYCLES);
  localparam logic [15:0] StepLast = 16'(STEPTO - 1);

  state_e      state_q, state_d;
  logic [7:0]  rstcnt_q, rstcnt_d;
  logic [15:0] stepcnt_q, stepcnt_d;
  logic        steperr_q, steperr_d;
  logic        enState;

  // State and counter registers. Reset lands in RESET with a full reset
  // count so the CPU always sees a complete reset pulse after n_rst.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= RESET;
      rstcnt_q  <= RstLoad;
      stepcnt_q <= '0;
      steperr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rstcnt_q  <= rstcnt_d;
      stepcnt_q <= stepcnt_d;
      steperr_q <= steperr_d;
    end
  end

  // Next-state logic. cpurst overrides everything, including freeze.
  // While frozen every other command is dropped and all state holds.
  // Within a state the if/else order gives the command priority
  // cpuhalt > cpustart > cpustep > cpucycle > cpuprint.
  always_comb begin
    state_d   = state_q;
    rstcnt_d  = rstcnt_q;
    stepcnt_d = stepcnt_q;
    steperr_d = steperr_q;
    if (cpurst) begin
      state_d   = RESET;
      rstcnt_d  = RstLoad;
      stepcnt_d = '0;
      steperr_d = 1'b0;
    end else if (!freeze) begin
      unique case (state_q)
        RESET: begin
          if (rstcnt_q <= 8'd1) state_d = HALT;
          else                  rstcnt_d = rstcnt_q - 8'd1;
        end
        HALT: begin
          if (cpuhalt)        state_d = HALT;
          else if (cpustart)  state_d = RUN;
          else if (cpustep) begin
            state_d   = STEP;
            stepcnt_d = '0;
          end
          else if (cpucycle)  state_d = CYCLE;
          else if (cpuprint)  state_d = PRINT;
        end
        RUN: begin
          if (cpuhalt) state_d = HALT;
        end
        STEP: begin
          // A retire in the timeout clock wins, so no error is flagged.
          if (cpuhalt || retired) begin
            state_d = HALT;
          end else if (stepcnt_q == StepLast) begin
            state_d   = HALT;
            steperr_d = 1'b1;
          end else begin
            stepcnt_d = stepcnt_q + 16'd1;
          end
        end
        CYCLE: state_d = HALT;
        PRINT: begin
          if (cpuhalt || printdone) state_d = HALT;
        end
        default: state_d = HALT;
      endcase
    end
  end

  // Outputs decode the state register only; freeze is the single
  // combinational path, so an upload stops the CPU immediately.
  assign enState   = (state_q == RUN) || (state_q == STEP) || (state_q == CYCLE);
  assign cpuen     = enState && !freeze;
  assign cpu_n_rst = (state_q != RESET);
  assign printreq  = (state_q == PRINT);
  assign running   = (state_q == RUN);
  assign steperr   = steperr_q;
  assign seqstate  = state_q;

`ifdef CPU_SEQ_CTL_CYCCNT_EN
  logic [31:0] cyccnt_q;

  // Counts CPU clocks that actually ran; wraps naturally at 32 bits.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)      cyccnt_q <= '0;
    else if (cpurst) cyccnt_q <= '0;
    else if (cpuen)  cyccnt_q <= cyccnt_q + 32'd1;
  end

  assign cyccnt = cyccnt_q;
`else
  assign cyccnt = 32'h0;
`endif

endmodule

// File: tb/tb_cpu_seq_ctl.sv
// ---------------------------------------------------------------------------
// tb_cpu_seq_ctl
//   Directed bench for cpu_seq_ctl with RSTCYCLES=4 and STEPTO=8. Inputs are
//   driven and outputs sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_seq_ctl;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        cpuhalt = 1'b0, cpustart = 1'b0, cpustep = 1'b0;
  logic        cpucycle = 1'b0, cpurst = 1'b0, cpuprint = 1'b0;
  logic        freeze = 1'b0, retired = 1'b0, printdone = 1'b0;
  logic        cpuen, cpu_n_rst, printreq, running, steperr;
  logic [2:0]  seqstate;
  logic [31:0] cyccnt;

  int testsRun  = 0;
  int failCount = 0;

  // Command vector layout {cpurst,cpuhalt,cpustart,cpustep,cpucycle,cpuprint}
  localparam logic [5:0] CmdRst   = 6'b100000;
  localparam logic [5:0] CmdHalt  = 6'b010000;
  localparam logic [5:0] CmdStart = 6'b001000;
  localparam logic [5:0] CmdStep  = 6'b000100;
  localparam logic [5:0] CmdCycle = 6'b000010;
  localparam logic [5:0] CmdPrint = 6'b000001;

  cpu_seq_ctl #(.RSTCYCLES(4), .STEPTO(8)) dut (
    .clk(clk), .n_rst(n_rst),
    .cpuhalt(cpuhalt), .cpustart(cpustart), .cpustep(cpustep),
    .cpucycle(cpucycle), .cpurst(cpurst), .cpuprint(cpuprint),
    .freeze(freeze), .retired(retired), .printdone(printdone),
    .cpuen(cpuen), .cpu_n_rst(cpu_n_rst), .printreq(printreq),
    .running(running), .steperr(steperr), .seqstate(seqstate),
    .cyccnt(cyccnt)
  );

  always #5 clk = ~clk;

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse a command set for exactly one sampling edge.
  task automatic applyStimulus(input logic [5:0] cmd);
    {cpurst, cpuhalt, cpustart, cpustep, cpucycle, cpuprint} = cmd;
    tick();
    {cpurst, cpuhalt, cpustart, cpustep, cpucycle, cpuprint} = 6'b0;
  endtask

  // Release n_rst between edges and count edges until cpu_n_rst rises.
  task automatic releaseAndCount(input string tag);
    int lowEdges;
    lowEdges = 0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      lowEdges++;
      if (cpu_n_rst) break;
    end
    checkOutput({tag, "_low_clocks"}, 32'(lowEdges), 32'd4);
    checkOutput({tag, "_state"}, 32'(seqstate), 32'd0);
    checkOutput({tag, "_cpuen"}, 32'(cpuen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int hiCount;
    logic [31:0] expCyc;

    // Power-on reset
    #1 n_rst = 1'b0;
    #1;
    checkOutput("rst_state", 32'(seqstate), 32'd5);
    checkOutput("rst_cpu_n_rst", 32'(cpu_n_rst), 32'd0);
    checkOutput("rst_cpuen", 32'(cpuen), 32'd0);
    checkOutput("rst_printreq", 32'(printreq), 32'd0);
    checkOutput("rst_steperr", 32'(steperr), 32'd0);
    checkOutput("rst_cyccnt", cyccnt, 32'd0);
    releaseAndCount("por");

    // Step retiring on the third enabled clock
    applyStimulus(CmdStep);
    checkOutput("step_en1", 32'(cpuen), 32'd1);
    checkOutput("step_state", 32'(seqstate), 32'd2);
    tick();
    checkOutput("step_en2", 32'(cpuen), 32'd1);
    tick();
    checkOutput("step_en3", 32'(cpuen), 32'd1);
    retired = 1'b1;
    tick();
    retired = 1'b0;
    checkOutput("step_done_en", 32'(cpuen), 32'd0);
    checkOutput("step_done_state", 32'(seqstate), 32'd0);
    checkOutput("step_done_err", 32'(steperr), 32'd0);

    // Step timeout after 8 clocks
    applyStimulus(CmdStep);
    for (int i = 0; i < 7; i++) tick();
    checkOutput("to_still_step", 32'(seqstate), 32'd2);
    checkOutput("to_no_err_yet", 32'(steperr), 32'd0);
    tick();
    checkOutput("to_state", 32'(seqstate), 32'd0);
    checkOutput("to_err", 32'(steperr), 32'd1);

    // retired outside STEP is ignored
    retired = 1'b1;
    tick();
    retired = 1'b0;
    checkOutput("ret_ignored_state", 32'(seqstate), 32'd0);
    checkOutput("ret_ignored_err", 32'(steperr), 32'd1);

    // cpurst clears steperr and holds CPU reset for 4 clocks
    applyStimulus(CmdRst);
    checkOutput("cpurst_state", 32'(seqstate), 32'd5);
    checkOutput("cpurst_err", 32'(steperr), 32'd0);
    checkOutput("cpurst_n_rst", 32'(cpu_n_rst), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    checkOutput("cpurst_still_reset", 32'(seqstate), 32'd5);
    tick();
    checkOutput("cpurst_halt", 32'(seqstate), 32'd0);
    checkOutput("cpurst_n_rst_hi", 32'(cpu_n_rst), 32'd1);

    // Retire in the same clock as the timeout counts as retired
    applyStimulus(CmdStep);
    for (int i = 0; i < 7; i++) tick();
    retired = 1'b1;
    tick();
    retired = 1'b0;
    checkOutput("ret_at_to_state", 32'(seqstate), 32'd0);
    checkOutput("ret_at_to_err", 32'(steperr), 32'd0);

    // cpuhalt aborts a step
    applyStimulus(CmdStep);
    tick();
    applyStimulus(CmdHalt);
    checkOutput("abort_step_state", 32'(seqstate), 32'd0);
    checkOutput("abort_step_en", 32'(cpuen), 32'd0);

    // cpuhalt beats cpustart, then run with freeze
    applyStimulus(CmdStart | CmdHalt);
    checkOutput("prio_halt", 32'(seqstate), 32'd0);
    applyStimulus(CmdStart);
    checkOutput("run_state", 32'(seqstate), 32'd1);
    checkOutput("run_running", 32'(running), 32'd1);
    checkOutput("run_en", 32'(cpuen), 32'd1);
    freeze = 1'b1;
    #1;
    checkOutput("frz_en", 32'(cpuen), 32'd0);
    applyStimulus(CmdHalt);
    checkOutput("frz_state", 32'(seqstate), 32'd1);
    checkOutput("frz_running", 32'(running), 32'd1);
    freeze = 1'b0;
    #1;
    checkOutput("unfrz_en", 32'(cpuen), 32'd1);
    applyStimulus(CmdPrint);
    checkOutput("run_print_req", 32'(printreq), 32'd0);
    checkOutput("run_print_state", 32'(seqstate), 32'd1);
    applyStimulus(CmdHalt);
    checkOutput("run_halt", 32'(seqstate), 32'd0);

    // Print with printdone after 5 clocks
    applyStimulus(CmdPrint);
    hiCount = 0;
    for (int i = 0; i < 5; i++) begin
      if (printreq) hiCount++;
      checkOutput("print_en", 32'(cpuen), 32'd0);
      if (i < 4) tick();
    end
    printdone = 1'b1;
    tick();
    printdone = 1'b0;
    checkOutput("print_hi_clocks", 32'(hiCount), 32'd5);
    checkOutput("print_req_off", 32'(printreq), 32'd0);
    checkOutput("print_state", 32'(seqstate), 32'd0);

    // Three single-clock cycles after a fresh cpurst
    applyStimulus(CmdRst);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("cyc_pre_state", 32'(seqstate), 32'd0);
    checkOutput("cyc_pre_cnt", cyccnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(CmdCycle);
      checkOutput("cycle_en", 32'(cpuen), 32'd1);
      checkOutput("cycle_state", 32'(seqstate), 32'd3);
      tick();
      checkOutput("cycle_after_en", 32'(cpuen), 32'd0);
      checkOutput("cycle_after_state", 32'(seqstate), 32'd0);
    end
`ifdef CPU_SEQ_CTL_CYCCNT_EN
    expCyc = 32'd3;
`else
    expCyc = 32'd0;
`endif
    checkOutput("cyccnt", cyccnt, expCyc);

    // n_rst mid-step restarts the full reset sequence
    applyStimulus(CmdStep);
    tick();
    n_rst = 1'b0;
    #1;
    checkOutput("midstep_rst_state", 32'(seqstate), 32'd5);
    checkOutput("midstep_rst_en", 32'(cpuen), 32'd0);
    checkOutput("midstep_rst_cyccnt", cyccnt, 32'd0);
    releaseAndCount("midstep");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
